cache_cpu_controller: RTL

CACHE_CPU_CONTROLLER -- requirements
Module: cache_cpu_controller

---
 rtl/cache_cpu_controller.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/cache_cpu_controller.sv
// CPU-side controller for a write-back MSI cache line store: serves hits locally,
// otherwise arbitrates for the bus, writes back a dirty victim, refills the line, or upgrades it.
module cache_cpu_controller #(
   parameter  int TAG_WIDTH     = 8,
   parameter  int INDEX_WIDTH   = 4,
   parameter  int OFFSET_WIDTH  = 2,
   parameter  int DATA_WIDTH    = 32,
   localparam int ADDRESS_WIDTH = TAG_WIDTH + INDEX_WIDTH + OFFSET_WIDTH
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     cpuRead,
   input  logic                     cpuWrite,
   input  logic [ADDRESS_WIDTH-1:0] cpuAddress,
   input  logic [DATA_WIDTH-1:0]    cpuDataIn,
   output logic [DATA_WIDTH-1:0]    cpuDataOut,
   output logic                     cpuDone,
   output logic [INDEX_WIDTH-1:0]   cacheIndex,
   output logic [OFFSET_WIDTH-1:0]  cacheOffset,
   output logic [TAG_WIDTH-1:0]     cacheTagIn,
   input  logic [TAG_WIDTH-1:0]     cacheTagOut,
   input  logic [1:0]               cacheStateOut,
   input  logic                     cacheHit,
   input  logic [DATA_WIDTH-1:0]    cacheDataOut,
   output logic                     cacheWriteTag,
   output logic                     cacheWriteState,
   output logic                     cacheWriteData,
   output logic [1:0]               cacheStateIn,
   output logic [DATA_WIDTH-1:0]    cacheDataIn,
   output logic                     busRequest,
   input  logic                     busGrant,
   output logic [1:0]               busCommand,
   output logic [ADDRESS_WIDTH-1:0] busAddress,
   output logic                     memRead,
   output logic                     memWrite,
   input  logic                     memAck,
   input  logic [DATA_WIDTH-1:0]    memDataIn,
   output logic [DATA_WIDTH-1:0]    memDataOut
);

   localparam logic [1:0] ST_INVALID  = 2'd0;
   localparam logic [1:0] ST_SHARED   = 2'd1;
   localparam logic [1:0] ST_MODIFIED = 2'd2;

   localparam logic [1:0] CMD_NONE    = 2'd0;
   localparam logic [1:0] CMD_READ    = 2'd1;
   localparam logic [1:0] CMD_READ_EX = 2'd2;
   localparam logic [1:0] CMD_INV     = 2'd3;

   typedef enum logic [2:0] {
      IDLE, HIT, WAIT_GRANT, WRITE_BACK, FILL, INVALIDATE, FINISH, DONE
   } state_t;

   state_t                  r_state;
   state_t                  w_next;
   logic [OFFSET_WIDTH-1:0] r_count;
   logic                    r_write;

   logic [TAG_WIDTH-1:0]    w_tag;
   logic [INDEX_WIDTH-1:0]  w_index;
   logic [OFFSET_WIDTH-1:0] w_offset;
   logic                    w_valid_hit;
   logic                    w_beat;
   logic                    w_last;
   logic [1:0]              w_cmd;
   logic                    w_memRead;
   logic                    w_memWrite;

   assign w_tag       = cpuAddress[ADDRESS_WIDTH-1 -: TAG_WIDTH];
   assign w_index     = cpuAddress[OFFSET_WIDTH +: INDEX_WIDTH];
   assign w_offset    = cpuAddress[OFFSET_WIDTH-1:0];
   assign w_valid_hit = cacheHit && (cacheStateOut == ST_SHARED || cacheStateOut == ST_MODIFIED);
   assign w_beat      = busGrant && memAck;
   assign w_last      = (r_count == '1);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_count <= '0;
         r_write <= 1'b0;
      end else begin
         r_state <= w_next;
         if (r_state == IDLE)
            r_write <= cpuWrite;
         // counter wraps naturally to 0 after the last word, ready for the refill burst
         if ((r_state == WRITE_BACK || r_state == FILL) && w_beat)
            r_count <= r_count + 1'b1;
      end
   end

   always_comb begin
      w_next          = r_state;
      cpuDataOut      = '0;
      cpuDone         = 1'b0;
      cacheIndex      = w_index;
      cacheTagIn      = w_tag;
      cacheOffset     = w_offset;
      cacheWriteTag   = 1'b0;
      cacheWriteState = 1'b0;
      cacheWriteData  = 1'b0;
      cacheStateIn    = ST_INVALID;
      cacheDataIn     = cpuDataIn;
      busRequest      = 1'b0;
      w_cmd           = CMD_NONE;
      busAddress      = cpuAddress;
      w_memRead       = 1'b0;
      w_memWrite      = 1'b0;
      memDataOut      = cacheDataOut;
      case (r_state)
         IDLE: begin
            if (cpuWrite) begin
               if (w_valid_hit && cacheStateOut == ST_MODIFIED) begin
                  cacheWriteData = 1'b1;
                  w_next         = DONE;
               end else begin
                  w_next = WAIT_GRANT;
               end
            end else if (cpuRead) begin
               w_next = w_valid_hit ? DONE : WAIT_GRANT;
            end
         end
         HIT: w_next = DONE;
         WAIT_GRANT: begin
            busRequest = 1'b1;
            // a snooper may have changed the line while we waited, so decide only now
            if (busGrant) begin
               if (r_write && w_valid_hit && cacheStateOut == ST_SHARED)
                  w_next = INVALIDATE;
               else if (!w_valid_hit && cacheStateOut == ST_MODIFIED)
                  w_next = WRITE_BACK;
               else
                  w_next = FILL;
            end
         end
         WRITE_BACK: begin
            busRequest  = 1'b1;
            cacheOffset = r_count;
            busAddress  = {cacheTagOut, w_index, r_count};
            w_memWrite  = 1'b1;
            if (w_beat && w_last)
               w_next = FILL;
         end
         FILL: begin
            busRequest  = 1'b1;
            cacheOffset = r_count;
            busAddress  = {w_tag, w_index, r_count};
            w_cmd       = r_write ? CMD_READ_EX : CMD_READ;
            w_memRead   = 1'b1;
            cacheDataIn = memDataIn;
            if (w_beat) begin
               cacheWriteData = 1'b1;
               if (w_last)
                  w_next = FINISH;
            end
         end
         INVALIDATE: begin
            busRequest = 1'b1;
            w_cmd      = CMD_INV;
            w_next     = FINISH;
         end
         FINISH: begin
            busRequest      = 1'b1;
            cacheWriteTag   = 1'b1;
            cacheWriteState = 1'b1;
            cacheStateIn    = r_write ? ST_MODIFIED : ST_SHARED;
            cacheWriteData  = r_write;
            w_next          = DONE;
         end
         DONE: begin
            cpuDone    = 1'b1;
            cpuDataOut = cacheDataOut;
            w_next     = IDLE;
         end
         default: w_next = IDLE;
      endcase
      // a write-hit in IDLE must not reach the cache while reset is held
      if (reset)
         cacheWriteData = 1'b0;
   end

   assign busCommand = busGrant ? w_cmd : CMD_NONE;
   assign memRead    = w_memRead && busGrant;
   assign memWrite   = w_memWrite && busGrant;

endmodule
